// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer: 2-FF sync, shared 1 ms tick, per-key FSM
// producing a debounced level plus press / release / long-press pulses.
module key_debounce_multi #(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W    = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W   = (LONG_MS > 0) ? $clog2(LONG_MS + 1) : 1;

  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]    DEB_LAST  = DEB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0]   HOLD_MAX  = HOLD_W'(LONG_MS);
  localparam logic                LONG_EN   = (LONG_MS != 0);
  localparam logic [NUM_KEYS-1:0] IDLE_PIN  = (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [NUM_KEYS-1:0] sync1_r, sync2_r;
  logic [NUM_KEYS-1:0] pressed_s;
  logic [TICK_W-1:0]   tick_cnt_r;
  logic                tick_s;
  logic [NUM_KEYS-1:0] press_v_s, release_v_s, long_v_s, state_v_s;

  // Two-stage synchroniser, preset to the released pin level
  always_ff @(posedge sclk) begin
    if (rst) begin
      sync1_r <= IDLE_PIN;
      sync2_r <= IDLE_PIN;
    end else begin
      sync1_r <= key_in;
      sync2_r <= sync1_r;
    end
  end

  assign pressed_s = sync2_r ^ IDLE_PIN;
  assign tick_s    = (tick_cnt_r == TICK_LAST);

  // Shared millisecond tick divider
  always_ff @(posedge sclk) begin
    if (rst) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  for (genvar ch = 0; ch < NUM_KEYS; ch++) begin : g_ch
    state_t              state_r, state_nxt_s;
    logic [DEB_W-1:0]    deb_cnt_r, deb_cnt_nxt_s;
    logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_nxt_s;
    logic                long_done_r, long_done_nxt_s;
    logic                p_s, press_s, release_s, long_s;

    assign p_s = pressed_s[ch];

    // Channel state and counters
    always_ff @(posedge sclk) begin
      if (rst) begin
        state_r     <= IDLE;
        deb_cnt_r   <= {DEB_W{1'b0}};
        hold_cnt_r  <= {HOLD_W{1'b0}};
        long_done_r <= 1'b0;
      end else begin
        state_r     <= state_nxt_s;
        deb_cnt_r   <= deb_cnt_nxt_s;
        hold_cnt_r  <= hold_cnt_nxt_s;
        long_done_r <= long_done_nxt_s;
      end
    end

    // Next state; a level change in a tick cycle discards that tick
    always_comb begin
      state_nxt_s     = state_r;
      deb_cnt_nxt_s   = deb_cnt_r;
      hold_cnt_nxt_s  = hold_cnt_r;
      long_done_nxt_s = long_done_r;
      if ((state_r == HELD || state_r == RELEASE_WAIT) && tick_s && (hold_cnt_r != HOLD_MAX)) begin
        hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
      end else begin
        hold_cnt_nxt_s = hold_cnt_r;
      end
      case (state_r)
        IDLE: begin
          if (p_s) begin
            state_nxt_s   = PRESS_WAIT;
            deb_cnt_nxt_s = {DEB_W{1'b0}};
          end else begin
            state_nxt_s   = IDLE;
          end
        end
        PRESS_WAIT: begin
          if (!p_s) begin
            state_nxt_s   = IDLE;
            deb_cnt_nxt_s = {DEB_W{1'b0}};
          end else if (tick_s && deb_cnt_r == DEB_LAST) begin
            state_nxt_s     = HELD;
            deb_cnt_nxt_s   = {DEB_W{1'b0}};
            hold_cnt_nxt_s  = {HOLD_W{1'b0}};
            long_done_nxt_s = 1'b0;
          end else if (tick_s) begin
            deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
          end else begin
            deb_cnt_nxt_s = deb_cnt_r;
          end
        end
        HELD: begin
          long_done_nxt_s = long_done_r | long_s;
          if (!p_s) begin
            state_nxt_s   = RELEASE_WAIT;
            deb_cnt_nxt_s = {DEB_W{1'b0}};
          end else begin
            state_nxt_s   = HELD;
          end
        end
        RELEASE_WAIT: begin
          if (p_s) begin
            state_nxt_s   = HELD;
            deb_cnt_nxt_s = {DEB_W{1'b0}};
          end else if (tick_s && deb_cnt_r == DEB_LAST) begin
            state_nxt_s   = IDLE;
            deb_cnt_nxt_s = {DEB_W{1'b0}};
          end else if (tick_s) begin
            deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
          end else begin
            deb_cnt_nxt_s = deb_cnt_r;
          end
        end
        default: begin
          state_nxt_s   = IDLE;
          deb_cnt_nxt_s = {DEB_W{1'b0}};
        end
      endcase
    end

    // Event decode; these are registered one cycle later with the level
    always_comb begin
      press_s   = 1'b0;
      release_s = 1'b0;
      long_s    = 1'b0;
      case (state_r)
        PRESS_WAIT:   press_s   = p_s && tick_s && (deb_cnt_r == DEB_LAST);
        RELEASE_WAIT: release_s = !p_s && tick_s && (deb_cnt_r == DEB_LAST);
        HELD:         long_s    = LONG_EN && !long_done_r && (hold_cnt_nxt_s == HOLD_MAX);
        default: begin
          press_s   = 1'b0;
          release_s = 1'b0;
          long_s    = 1'b0;
        end
      endcase
    end

    assign press_v_s[ch]   = press_s;
    assign release_v_s[ch] = release_s;
    assign long_v_s[ch]    = long_s;
    assign state_v_s[ch]   = (state_nxt_s == HELD) || (state_nxt_s == RELEASE_WAIT);
  end

  // Registered outputs
  always_ff @(posedge sclk) begin
    if (rst) begin
      key_state   <= {NUM_KEYS{1'b0}};
      key_press   <= {NUM_KEYS{1'b0}};
      key_release <= {NUM_KEYS{1'b0}};
      key_long    <= {NUM_KEYS{1'b0}};
    end else begin
      key_state   <= state_v_s;
      key_press   <= press_v_s;
      key_release <= release_v_s;
      key_long    <= long_v_s;
    end
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: a level/run-length reference model
// queues expected pulses; a negedge monitor compares what the DUT emits.
module tb_key_debounce_multi;

  localparam int TD  = 10;
  localparam int DEB = 3;
  localparam int LNG = 8;

  logic       sclk;
  logic       rst;
  logic [1:0] key_in;
  logic [1:0] key_state, key_press, key_release, key_long;

  int checks = 0;
  int errors = 0;

  key_debounce_multi #(
    .NUM_KEYS(2), .CLK_FREQ_HZ(10_000), .DEBOUNCE_MS(3), .LONG_MS(8), .ACTIVE_LOW(1)
  ) dut (
    .sclk(sclk), .rst(rst), .key_in(key_in),
    .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct {
    int         cyc;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lg;
  } ev_t;

  ev_t        exp_q[$];
  int         ecnt = 0;
  bit         started = 1'b0;
  logic [1:0] exp_state = 2'b00;

  // Reference model: accepted level per key, run of ticks spent disagreeing with it
  int         tcnt;
  logic [1:0] s1, s2;
  int         lvl[2], wt[2], run[2], hold[2], done[2];

  always @(posedge sclk) begin
    logic [1:0] pv, pr, rl, lg;
    logic       tk;
    ev_t        ev;
    ecnt++;
    if (rst) begin
      tcnt = 0; s1 = 2'b11; s2 = 2'b11;
      for (int c = 0; c < 2; c++) begin
        lvl[c] = 0; wt[c] = 0; run[c] = 0; hold[c] = 0; done[c] = 0;
      end
      exp_state = 2'b00;
      started = 1'b1;
    end else if (started) begin
      tk = (tcnt == TD - 1);
      tcnt = tk ? 0 : tcnt + 1;
      pv = ~s2;
      s2 = s1;
      s1 = key_in;
      pr = 2'b00; rl = 2'b00; lg = 2'b00;
      for (int c = 0; c < 2; c++) begin
        if (lvl[c] == 1 && tk && hold[c] < LNG) hold[c]++;
        if (lvl[c] == 1 && wt[c] == 0 && done[c] == 0 && hold[c] == LNG) begin
          lg[c] = 1'b1; done[c] = 1;
        end
        if (int'(pv[c]) != lvl[c]) begin
          if (wt[c] == 0) begin
            wt[c] = 1; run[c] = 0;
          end else if (tk) begin
            run[c]++;
            if (run[c] == DEB) begin
              wt[c] = 0; run[c] = 0; lvl[c] = 1 - lvl[c];
              if (lvl[c] == 1) begin
                pr[c] = 1'b1; hold[c] = 0; done[c] = 0;
              end else begin
                rl[c] = 1'b1;
              end
            end
          end
        end else begin
          wt[c] = 0; run[c] = 0;
        end
      end
      exp_state = {lvl[1] == 1, lvl[0] == 1};
      if ((pr | rl | lg) != 2'b00) begin
        ev.cyc = ecnt; ev.pr = pr; ev.rl = rl; ev.lg = lg;
        exp_q.push_back(ev);
      end
    end
  end

  // Monitor: level every cycle, pulses popped from the expectation queue
  always @(negedge sclk) begin
    ev_t ev;
    if (started) begin
      checks++;
      if (key_state !== exp_state) begin
        errors++;
        $display("FAIL key_state cyc=%0d: got %b, expected %b", ecnt, key_state, exp_state);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < ecnt) begin
        ev = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missed_event cyc=%0d: got nothing, expected press=%b rel=%b long=%b",
                 ev.cyc, ev.pr, ev.rl, ev.lg);
      end
      if ((key_press | key_release | key_long) != 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d: got press=%b rel=%b long=%b, expected none",
                   ecnt, key_press, key_release, key_long);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != ecnt || ev.pr !== key_press || ev.rl !== key_release || ev.lg !== key_long) begin
            errors++;
            $display("FAIL event cyc=%0d: got press=%b rel=%b long=%b, expected cyc=%0d press=%b rel=%b long=%b",
                     ecnt, key_press, key_release, key_long, ev.cyc, ev.pr, ev.rl, ev.lg);
          end
        end
      end
    end
  end

  function automatic logic [1:0] sel(input int kind);
    case (kind)
      0:       return key_press;
      1:       return key_release;
      default: return key_long;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Waits (bounded) for a pulse of one kind under mask; checks delay window and full vector
  task automatic wait_pulse(input int kind, input logic [1:0] mask, input logic [1:0] exp_vec,
                            input int lo, input int hi, input string name);
    int   n;
    bit   seen;
    logic [1:0] v;
    n = 0; seen = 1'b0; v = 2'b00;
    while (!seen && n <= hi + 5) begin
      @(negedge sclk);
      n++;
      v = sel(kind);
      if ((v & mask) != 2'b00) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no pulse within %0d cycles, expected %b after %0d..%0d", name, hi + 5, exp_vec, lo, hi);
    end else if (n < lo || n > hi || v !== exp_vec) begin
      errors++;
      $display("FAIL %s: got %b after %0d cycles, expected %b after %0d..%0d", name, v, n, exp_vec, lo, hi);
    end
  endtask

  initial begin
    int rem[2];
    rst = 1'b1;
    key_in = 2'b11;
    repeat (3) @(negedge sclk);
    rst = 1'b0;

    // Quiet reset
    repeat (200) @(negedge sclk);
    chk("quiet_outputs", {key_state, key_press, key_release, key_long}, 8'h00);

    // Clean press, then single long press
    key_in[0] = 1'b0;
    wait_pulse(0, 2'b01, 2'b01, 23, 33, "clean_press");
    wait_pulse(2, 2'b01, 2'b01, 80, 80, "long_press");
    repeat (150) @(negedge sclk);
    chk("held_state", {6'h00, key_state}, 8'h01);

    // Bouncy release from HELD
    for (int i = 0; i < 3; i++) begin
      key_in[0] = 1'b1;
      repeat ($urandom_range(5, 15)) @(negedge sclk);
      key_in[0] = 1'b0;
      repeat (4) @(negedge sclk);
    end
    key_in[0] = 1'b1;
    wait_pulse(1, 2'b01, 2'b01, 1, 40, "bouncy_release");
    repeat (60) @(negedge sclk);
    chk("released_state", {6'h00, key_state}, 8'h00);

    // Bounce reject
    for (int i = 0; i < 5; i++) begin
      key_in[0] = 1'b0;
      repeat (15) @(negedge sclk);
      key_in[0] = 1'b1;
      repeat ($urandom_range(10, 30)) @(negedge sclk);
    end
    chk("bounce_state", {6'h00, key_state}, 8'h00);

    // Two keys together, release only key 1
    key_in = 2'b00;
    wait_pulse(0, 2'b11, 2'b11, 23, 33, "dual_press");
    repeat (5) @(negedge sclk);
    key_in[1] = 1'b1;
    wait_pulse(1, 2'b11, 2'b10, 23, 33, "single_release");

    // Reset while key 0 held
    rst = 1'b1;
    @(negedge sclk);
    rst = 1'b0;
    chk("reset_outputs", {key_state, key_press, key_release, key_long}, 8'h00);
    wait_pulse(0, 2'b11, 2'b01, 29, 31, "press_after_reset");

    // Randomized free run
    rem[0] = 0; rem[1] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge sclk);
      rst = ($urandom_range(0, 2499) == 0);
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          key_in[c] = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 140) : $urandom_range(1, 12);
        end else begin
          rem[c]--;
        end
      end
    end
    rst = 1'b0;
    key_in = 2'b11;
    repeat (200) @(negedge sclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected events, expected 0", exp_q.size());
    end
    chk("final_state", {6'h00, key_state}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
